// File: rtl/snn_stim_sequencer.sv
// snn_stim_sequencer
//   Image-stimulus engine for the SNN digit classifier. For each of up to
//   MAX_SAMPLES images it reads IMG_BITS pixels from a 1-bit registered ROM,
//   packs them LSB-first into bytes, streams the bytes to uart_tx, then waits
//   for the classifier's result byte from uart_rx. Each result is scored
//   against the expected digit and pass/fail totals are kept.
//
//   Optional feature macro: SNN_STIM_TIMEOUT_EN
//     defined     : WAIT_RX gives up after TIMEOUT_CYCLES cycles, counts a
//                   timeout, sets last_digit to 4'hF and moves to the next sample
//     not defined : WAIT_RX waits indefinitely and to_cnt is tied to 0
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, num_samples  run request pulse and image count (clamped to MAX_SAMPLES)
//   mem_addr, mem_data  pixel ROM address / data (data 1 cycle after address)
//   exp_idx, exp_digit  current sample index / expected digit for that index
//   tx_start, tx_data   byte handoff to uart_tx, tx_rdy is its idle flag
//   rx_rdy, rx_data     result byte from uart_rx
//   busy, done          run in progress / 1-cycle end-of-run pulse
//   pass_cnt, fail_cnt, to_cnt, last_digit   run results
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// FETCH    | presenting 8 pixel addresses, shifting in returned bits
// LOAD     | shifting in the last pixel of the byte
// SEND     | waiting for tx_rdy, then pulsing tx_start
// WAIT_TX  | waiting for uart_tx to finish the byte
// WAIT_RX  | waiting for the classifier result (optionally timed)
// CHECK    | scoring last_digit against exp_digit
// FIN      | end of run, done pulse follows
module snn_stim_sequencer #(
    parameter int IMG_BITS       = 784,
    parameter int MAX_SAMPLES    = 16,
    parameter int ADDR_W         = 14,
    parameter int SIDX_W         = 4,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIDX_W:0]   num_samples,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic [SIDX_W-1:0] exp_idx,
    input  logic [3:0]        exp_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_rdy,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  to_cnt,
    output logic [3:0]        last_digit
);

    localparam int BYTES  = IMG_BITS / 8;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_WAIT_TX, S_WAIT_RX, S_CHECK, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [SIDX_W:0]     nsamp_q, nsamp_d;
    logic [SIDX_W-1:0]   exp_idx_q, exp_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          shreg_q, shreg_d;
    logic                tx_wait_q, tx_wait_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
    logic [3:0]          last_digit_q, last_digit_d;

    logic [SIDX_W:0]     nsamp_clamped;
    logic [SIDX_W:0]     idx_plus1;
    logic                last_sample;
    logic                advance;

    // Only the low nibble of the result byte carries the digit.
    logic unused_rx_hi;
    assign unused_rx_hi = ^rx_data[7:4];

`ifdef SNN_STIM_TIMEOUT_EN
    localparam int TMR_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
    assign to_cnt = to_cnt_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign to_cnt = '0;
`endif

    assign nsamp_clamped = (num_samples > (SIDX_W+1)'(MAX_SAMPLES)) ?
                           (SIDX_W+1)'(MAX_SAMPLES) : num_samples;
    assign idx_plus1     = {1'b0, exp_idx_q} + 1'b1;
    assign last_sample   = (idx_plus1 >= nsamp_q);

    always_comb begin
        state_d      = state_q;
        nsamp_d      = nsamp_q;
        exp_idx_d    = exp_idx_q;
        byte_idx_d   = byte_idx_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        shreg_d      = shreg_q;
        tx_wait_d    = tx_wait_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        last_digit_d = last_digit_q;
        tx_start     = 1'b0;
        advance      = 1'b0;
`ifdef SNN_STIM_TIMEOUT_EN
        tmr_d        = tmr_q;
        to_cnt_d     = to_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nsamp_d    = nsamp_clamped;
                    exp_idx_d  = '0;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                    addr_d     = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
`ifdef SNN_STIM_TIMEOUT_EN
                    to_cnt_d   = '0;
`endif
                    busy_d     = 1'b1;
                    state_d    = (nsamp_clamped == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: begin
                // mem_data lags the address by one cycle, so the first
                // FETCH cycle has nothing valid to shift in yet.
                if (bit_cnt_q != 3'd0) shreg_d = {mem_data, shreg_q[7:1]};
                addr_d    = addr_q + 1'b1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = {mem_data, shreg_q[7:1]};
                state_d = S_SEND;
            end
            S_SEND: begin
                if (tx_rdy) begin
                    tx_start  = 1'b1;
                    tx_wait_d = 1'b1;
                    state_d   = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // uart_tx may not have dropped tx_rdy yet in the cycle right
                // after the pulse, so that cycle is skipped.
                if (tx_wait_q) begin
                    tx_wait_d = 1'b0;
                end else if (tx_rdy) begin
                    if (byte_idx_q == BIDX_W'(BYTES - 1)) begin
                        byte_idx_d = '0;
                        state_d    = S_WAIT_RX;
`ifdef SNN_STIM_TIMEOUT_EN
                        tmr_d      = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WAIT_RX: begin
                if (rx_rdy) begin
                    last_digit_d = rx_data[3:0];
                    state_d      = S_CHECK;
                end
`ifdef SNN_STIM_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 1'b1;
                    last_digit_d = 4'hF;
                    advance      = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`endif
            end
            S_CHECK: begin
                if (last_digit_q == exp_digit) begin
                    if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
                end else begin
                    if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
                end
                advance = 1'b1;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Pixel addresses of consecutive samples are contiguous, so addr_q
        // simply keeps counting into the next image.
        if (advance) begin
            exp_idx_d = exp_idx_q + 1'b1;
            state_d   = last_sample ? S_FIN : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            nsamp_q      <= '0;
            exp_idx_q    <= '0;
            byte_idx_q   <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            shreg_q      <= '0;
            tx_wait_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_cnt_q   <= '0;
            fail_cnt_q   <= '0;
            last_digit_q <= '0;
`ifdef SNN_STIM_TIMEOUT_EN
            tmr_q        <= '0;
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            nsamp_q      <= nsamp_d;
            exp_idx_q    <= exp_idx_d;
            byte_idx_q   <= byte_idx_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            shreg_q      <= shreg_d;
            tx_wait_q    <= tx_wait_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            last_digit_q <= last_digit_d;
`ifdef SNN_STIM_TIMEOUT_EN
            tmr_q        <= tmr_d;
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign mem_addr   = addr_q;
    assign exp_idx    = exp_idx_q;
    assign tx_data    = shreg_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_cnt   = pass_cnt_q;
    assign fail_cnt   = fail_cnt_q;
    assign last_digit = last_digit_q;

endmodule

// File: tb/tb_snn_stim_sequencer.sv
module tb_snn_stim_sequencer;

    localparam int IMG_BITS = 784;
    localparam int MAX_SAMPLES = 16;
    localparam int ADDR_W = 14;
    localparam int SIDX_W = 4;
    localparam int CNT_W = 8;
    localparam int TO_CYC = 100;
    localparam int BYTES = IMG_BITS / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [SIDX_W:0]   num_samples = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data;
    logic [SIDX_W-1:0] exp_idx;
    logic [3:0]        exp_digit;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_rdy = 1'b1;
    logic              rx_rdy = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              busy, done;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, to_cnt;
    logic [3:0]        last_digit;

    snn_stim_sequencer #(
        .IMG_BITS(IMG_BITS), .MAX_SAMPLES(MAX_SAMPLES), .ADDR_W(ADDR_W),
        .SIDX_W(SIDX_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .exp_idx(exp_idx), .exp_digit(exp_digit),
        .tx_start(tx_start), .tx_data(tx_data), .tx_rdy(tx_rdy),
        .rx_rdy(rx_rdy), .rx_data(rx_data),
        .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .to_cnt(to_cnt),
        .last_digit(last_digit)
    );

    always #5 clk = ~clk;

    // Pixel ROM with one cycle of read latency.
    logic mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) mem_data <= mem[mem_addr];

    logic [3:0] exp_tab [0:15];
    assign exp_digit = exp_tab[exp_idx];

    logic [7:0] resp [0:15];
    bit         resp_skip [0:15];
    bit         resp_en = 1'b0;
    int         inject_at = 0;
    int         run_base = 0;

    int         vecs = 0;
    int         fails = 0;

    // Monitor-owned state.
    int         bytes_sent = 0;
    int         byte_errs = 0;
    int         tx_notrdy = 0;
    int         done_cnt = 0;
    int         rx_delay = 0;
    int         resp_sel = 0;
    int         tx_hold = 0;
    bit         drop_pend = 1'b0;
    logic [7:0] first_byte = 8'h00;

    // uart_tx / uart_rx behaviour plus byte scoreboard, all on the falling edge.
    always @(negedge clk) begin
        logic [7:0] e;
        int rel, s, k;
        if (rx_rdy) rx_rdy = 1'b0;
        if (done) done_cnt++;
        if (tx_start) begin
            if (!tx_rdy) tx_notrdy++;
            rel = bytes_sent - run_base;
            s = rel / BYTES;
            k = rel % BYTES;
            for (int j = 0; j < 8; j++) e[j] = mem[(s * IMG_BITS + 8 * k + j) % (1 << ADDR_W)];
            if (rel == 0) first_byte = tx_data;
            if (tx_data !== e) byte_errs++;
            bytes_sent++;
            rel = rel + 1;
            if (resp_en && (rel % BYTES == 0) && s < 16) begin
                if (!resp_skip[s]) begin
                    rx_delay = 25;
                    resp_sel = s;
                end
            end
            if (inject_at != 0 && rel == inject_at) begin
                rx_rdy = 1'b1;
                rx_data = 8'h39;
            end
            drop_pend = 1'b1;
        end else if (drop_pend) begin
            tx_rdy = 1'b0;
            tx_hold = 2;
            drop_pend = 1'b0;
        end else if (tx_hold > 0) begin
            tx_hold--;
            if (tx_hold == 0) tx_rdy = 1'b1;
        end
        if (rx_delay > 0) begin
            rx_delay--;
            if (rx_delay == 0) begin
                rx_rdy = 1'b1;
                rx_data = resp[resp_sel];
            end
        end
    end

    task automatic pulse_start(input logic [SIDX_W:0] n);
        @(negedge clk);
        run_base = bytes_sent;
        num_samples = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecs++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        vecs++; if (mem_addr !== '0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        vecs++; if (exp_idx !== '0) begin fails++; $display("FAIL reset_idx: got %h want 0", exp_idx); end
        vecs++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin
            fails++; $display("FAIL reset_tx: got %b/%h want 0/00", tx_start, tx_data); end
        vecs++; if ({pass_cnt, fail_cnt, to_cnt, last_digit} !== '0) begin
            fails++; $display("FAIL reset_cnts: got %h/%h/%h/%h want 0", pass_cnt, fail_cnt, to_cnt, last_digit); end
        num_samples = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL start_in_reset: busy got %b want 0", busy); end
        vecs++; if (bytes_sent !== 0) begin fails++; $display("FAIL start_in_reset_tx: got %0d bytes want 0", bytes_sent); end
    endtask

    task automatic test_three_samples();
        bit to;
        int b0, d0;
        exp_tab[0] = 4'd0; exp_tab[1] = 4'd2; exp_tab[2] = 4'd7;
        resp[0] = 8'h30; resp[1] = 8'h32; resp[2] = 8'h35;
        resp_en = 1'b1;
        b0 = bytes_sent; d0 = done_cnt;
        pulse_start(5'd3);
        for (int i = 0; i < 2000 && (bytes_sent - b0) < 5; i++) @(negedge clk);
        // A start while busy must not restart or resize the run.
        pulse_start(5'd1);
        run_base = b0;
        wait_done(20000, to);
        vecs++; if (to) begin fails++; $display("FAIL run3_timeout: done not seen, got 0 want 1"); end
        vecs++; if (first_byte !== 8'h0D) begin fails++; $display("FAIL pack_first: got %h want 0d", first_byte); end
        vecs++; if (bytes_sent - b0 !== 3 * BYTES) begin
            fails++; $display("FAIL run3_bytes: got %0d want %0d", bytes_sent - b0, 3 * BYTES); end
        vecs++; if (byte_errs !== 0) begin fails++; $display("FAIL run3_data: got %0d bad bytes want 0", byte_errs); end
        vecs++; if (tx_notrdy !== 0) begin fails++; $display("FAIL tx_while_busy: got %0d want 0", tx_notrdy); end
        vecs++; if (pass_cnt !== 8'd2) begin fails++; $display("FAIL run3_pass: got %0d want 2", pass_cnt); end
        vecs++; if (fail_cnt !== 8'd1) begin fails++; $display("FAIL run3_fail: got %0d want 1", fail_cnt); end
        vecs++; if (last_digit !== 4'd5) begin fails++; $display("FAIL run3_last: got %h want 5", last_digit); end
        vecs++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL run3_done_cnt: got %0d want 1", done_cnt - d0); end
        vecs++; if (busy !== 1'b0) begin fails++; $display("FAIL run3_busy: got %b want 0", busy); end
        resp_en = 1'b0;
    endtask

    task automatic test_zero_samples();
        int b0;
        b0 = bytes_sent;
        @(negedge clk);
        num_samples = 5'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vecs++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL zero_c1: busy/done got %b/%b want 1/0", busy, done); end
        @(negedge clk);
        vecs++; if (busy !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL zero_c2: busy/done got %b/%b want 0/1", busy, done); end
        vecs++; if (pass_cnt !== '0 || fail_cnt !== '0) begin
            fails++; $display("FAIL zero_cnts: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
        @(negedge clk);
        vecs++; if (done !== 1'b0) begin fails++; $display("FAIL zero_pulse_len: got %b want 0", done); end
        vecs++; if (bytes_sent !== b0) begin fails++; $display("FAIL zero_tx: got %0d bytes want 0", bytes_sent - b0); end
    endtask

    task automatic test_rx_inject();
        bit to;
        int b0;
        exp_tab[0] = 4'd6;
        resp[0] = 8'h36;
        resp_en = 1'b1;
        inject_at = 10;
        b0 = bytes_sent;
        pulse_start(5'd1);
        for (int i = 0; i < 2000 && (bytes_sent - b0) < 12; i++) @(negedge clk);
        vecs++; if (pass_cnt !== '0 || fail_cnt !== '0 || busy !== 1'b1) begin
            fails++; $display("FAIL inject_mid: pass/fail/busy got %0d/%0d/%b want 0/0/1", pass_cnt, fail_cnt, busy); end
        wait_done(5000, to);
        vecs++; if (to) begin fails++; $display("FAIL inject_timeout: done not seen, got 0 want 1"); end
        vecs++; if (pass_cnt !== 8'd1 || fail_cnt !== 8'd0) begin
            fails++; $display("FAIL inject_cnts: got %0d/%0d want 1/0", pass_cnt, fail_cnt); end
        vecs++; if (last_digit !== 4'd6) begin fails++; $display("FAIL inject_last: got %h want 6", last_digit); end
        vecs++; if (bytes_sent - b0 !== BYTES) begin
            fails++; $display("FAIL inject_bytes: got %0d want %0d", bytes_sent - b0, BYTES); end
        inject_at = 0;
        resp_en = 1'b0;
    endtask

    task automatic test_clamp();
        bit to;
        int b0;
        for (int i = 0; i < 16; i++) begin
            exp_tab[i] = 4'(i % 10);
            resp[i] = 8'h30 + 8'(i % 10);
        end
        resp[15] = 8'h31;
        resp_en = 1'b1;
        b0 = bytes_sent;
        pulse_start(5'd31);
        wait_done(40000, to);
        vecs++; if (to) begin fails++; $display("FAIL clamp_timeout: done not seen, got 0 want 1"); end
        vecs++; if (bytes_sent - b0 !== 16 * BYTES) begin
            fails++; $display("FAIL clamp_bytes: got %0d want %0d", bytes_sent - b0, 16 * BYTES); end
        vecs++; if (pass_cnt !== 8'd15 || fail_cnt !== 8'd1) begin
            fails++; $display("FAIL clamp_cnts: got %0d/%0d want 15/1", pass_cnt, fail_cnt); end
        vecs++; if (byte_errs !== 0) begin fails++; $display("FAIL clamp_data: got %0d bad bytes want 0", byte_errs); end
        resp_en = 1'b0;
    endtask

`ifdef SNN_STIM_TIMEOUT_EN
    task automatic test_timeout();
        bit to;
        int b0;
        exp_tab[0] = 4'd3; exp_tab[1] = 4'd4;
        resp[1] = 8'h34;
        resp_skip[0] = 1'b1;
        resp_en = 1'b1;
        b0 = bytes_sent;
        pulse_start(5'd2);
        for (int i = 0; i < 5000 && (bytes_sent - b0) < BYTES + 1; i++) @(negedge clk);
        vecs++; if (to_cnt !== 8'd1 || last_digit !== 4'hF) begin
            fails++; $display("FAIL to_mid: to_cnt/last got %0d/%h want 1/f", to_cnt, last_digit); end
        vecs++; if (pass_cnt !== '0 || fail_cnt !== '0) begin
            fails++; $display("FAIL to_mid_cnts: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
        wait_done(5000, to);
        vecs++; if (to) begin fails++; $display("FAIL to_run_timeout: done not seen, got 0 want 1"); end
        vecs++; if (to_cnt !== 8'd1 || pass_cnt !== 8'd1 || fail_cnt !== 8'd0) begin
            fails++; $display("FAIL to_end_cnts: got to%0d/p%0d/f%0d want 1/1/0", to_cnt, pass_cnt, fail_cnt); end
        vecs++; if (last_digit !== 4'd4 || bytes_sent - b0 !== 2 * BYTES) begin
            fails++; $display("FAIL to_end_last: got %h/%0d want 4/%0d", last_digit, bytes_sent - b0, 2 * BYTES); end
        resp_skip[0] = 1'b0;
        resp_en = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int d0;
        d0 = done_cnt;
        resp_en = 1'b0;
        pulse_start(5'd1);
        repeat (10000) @(negedge clk);
        vecs++; if (busy !== 1'b1 || done_cnt !== d0) begin
            fails++; $display("FAIL wait_forever: busy/dones got %b/%0d want 1/0", busy, done_cnt - d0); end
        vecs++; if (to_cnt !== '0) begin fails++; $display("FAIL to_tied: got %0d want 0", to_cnt); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (busy !== 1'b0 || done_cnt !== d0) begin
            fails++; $display("FAIL abort: busy/dones got %b/%0d want 0/0", busy, done_cnt - d0); end
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 1'($urandom_range(0, 1));
        mem[0] = 1'b1; mem[1] = 1'b0; mem[2] = 1'b1; mem[3] = 1'b1;
        mem[4] = 1'b0; mem[5] = 1'b0; mem[6] = 1'b0; mem[7] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_tab[i] = 4'd0;
            resp[i] = 8'h30;
            resp_skip[i] = 1'b0;
        end
        test_reset();
        test_three_samples();
        test_zero_samples();
        test_rx_inject();
        test_clamp();
`ifdef SNN_STIM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
